// File: rtl/display_fill_pkg.sv
// rtl/display_fill_pkg.sv - shared display command opcodes, header layout and fill FSM states
//
// Imported by display_fill and by any other display block that emits the
// window-setup header (CASET / RASET / RAMWR). Contents:
//   CMD_CASET, CMD_RASET, CMD_RAMWR : controller opcodes
//   HEAD_LEN                        : number of words in the window header
//   fill_state_t                    : IDLE / HEAD / PIX
//   head_word()                     : header word k for a given window
package display_fill_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;
   localparam int         HEAD_LEN  = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      PIX  = 2'd2
   } fill_state_t;

   // Word layout is {dc, byte}: dc=0 for opcodes, dc=1 for parameters.
   function automatic logic [8:0] head_word(
      input logic [3:0]  idx,
      input logic [15:0] x0,
      input logic [15:0] x1,
      input logic [15:0] y0,
      input logic [15:0] y1
   );
      logic [8:0] w;
      w = 9'h000;
      case (idx)
         4'd0:    w = {1'b0, CMD_CASET};
         4'd1:    w = {1'b1, x0[15:8]};
         4'd2:    w = {1'b1, x0[7:0]};
         4'd3:    w = {1'b1, x1[15:8]};
         4'd4:    w = {1'b1, x1[7:0]};
         4'd5:    w = {1'b0, CMD_RASET};
         4'd6:    w = {1'b1, y0[15:8]};
         4'd7:    w = {1'b1, y0[7:0]};
         4'd8:    w = {1'b1, y1[15:8]};
         4'd9:    w = {1'b1, y1[7:0]};
         4'd10:   w = {1'b0, CMD_RAMWR};
         default: w = 9'h000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/display_fill_if.sv
// rtl/display_fill_if.sv - request and word-stream bundle for display_fill
//
// Signals:
//   start, x0, x1, y0, y1, color : fill request (requester -> filler)
//   get                          : consumer pops the presented word
//   out[8:0]                     : {dc, byte} word presented to the consumer
//   empty                        : no valid word on out
//   busy, done                   : fill status
// Modports:
//   slave  : the filler (display_fill)
//   master : the requester / consumer side
interface display_fill_if #(parameter int W = 8);

   logic         start;
   logic [W-1:0] x0;
   logic [W-1:0] x1;
   logic [W-1:0] y0;
   logic [W-1:0] y1;
   logic [15:0]  color;
   logic         get;
   logic [8:0]   out;
   logic         empty;
   logic         busy;
   logic         done;

   modport slave (
      input  start, x0, x1, y0, y1, color, get,
      output out, empty, busy, done
   );

   modport master (
      output start, x0, x1, y0, y1, color, get,
      input  out, empty, busy, done
   );

endinterface

// File: rtl/display_window_walk.sv
// rtl/display_window_walk.sv - column/row/byte-phase walker over an inclusive pixel window
//
// Ports:
//   clock, reset     : system clock, asynchronous active-high reset
//   i_load           : start a walk at (x0, y0), high-byte phase
//   i_pop            : the current pixel byte was consumed
//   i_x0..i_y1       : inclusive window corners (held stable during a walk)
//   o_phase          : 0 = high colour byte is due, 1 = low colour byte is due
//   o_last           : the low byte of the final pixel is due
module display_window_walk #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_load,
   input  logic         i_pop,
   input  logic [W-1:0] i_x0,
   input  logic [W-1:0] i_x1,
   input  logic [W-1:0] i_y0,
   input  logic [W-1:0] i_y1,
   output logic         o_phase,
   output logic         o_last
);

   logic [W-1:0] r_col;
   logic [W-1:0] r_row;
   logic         r_phase;
   logic         w_col_end;
   logic         w_row_end;

   // Equality-only compares: a window edge at 2^W-1 never needs a wrap.
   assign w_col_end = (r_col == i_x1);
   assign w_row_end = (r_row == i_y1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_col   <= '0;
         r_row   <= '0;
         r_phase <= 1'b0;
      end else if (i_load) begin
         r_col   <= i_x0;
         r_row   <= i_y0;
         r_phase <= 1'b0;
      end else if (i_pop) begin
         if (!r_phase) begin
            r_phase <= 1'b1;
         end else begin
            r_phase <= 1'b0;
            if (w_col_end) begin
               r_col <= i_x0;
               // Row holds on the final pixel so y1 = 2^W-1 cannot overrun.
               if (!w_row_end) begin
                  r_row <= r_row + 1'b1;
               end
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   assign o_phase = r_phase;
   assign o_last  = r_phase & w_col_end & w_row_end;

endmodule

// File: rtl/display_fill.sv
// rtl/display_fill.sv - window fill word generator feeding an SPI display link
//
// Emits the CASET/RASET/RAMWR window header followed by one RGB565 colour
// per pixel of an inclusive window, as {dc, byte} words popped by a
// get/empty consumer.
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-high reset
//   bus.slave  : start/x0/x1/y0/y1/color request, get/out/empty word stream,
//                busy and done status
module display_fill
   import display_fill_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clock,
   input  logic           reset,
   display_fill_if.slave  bus
);

   localparam logic [3:0] HEAD_LAST = 4'(HEAD_LEN - 1);

   fill_state_t  r_state;
   logic [3:0]   r_idx;
   logic [W-1:0] r_x0;
   logic [W-1:0] r_x1;
   logic [W-1:0] r_y0;
   logic [W-1:0] r_y1;
   logic [15:0]  r_color;
   logic [8:0]   r_out;
   logic         r_empty;
   logic         r_busy;
   logic         r_done;

   logic         w_pop;
   logic         w_accept;
   logic         w_walk_load;
   logic         w_walk_pop;
   logic         w_phase;
   logic         w_last;

   assign w_pop       = bus.get & ~r_empty;
   assign w_accept    = bus.start & (bus.x0 <= bus.x1) & (bus.y0 <= bus.y1);
   assign w_walk_load = (r_state == HEAD) & w_pop & (r_idx == HEAD_LAST);
   assign w_walk_pop  = (r_state == PIX) & w_pop;

   display_window_walk #(.W(W)) u_walk (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_walk_load),
      .i_pop   (w_walk_pop),
      .i_x0    (r_x0),
      .i_x1    (r_x1),
      .i_y0    (r_y0),
      .i_y1    (r_y1),
      .o_phase (w_phase),
      .o_last  (w_last)
   );

   // r_out always holds the word that is due next, so each pop loads the
   // following word and the stream sustains one word per cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= 4'd0;
         r_x0    <= '0;
         r_x1    <= '0;
         r_y0    <= '0;
         r_y1    <= '0;
         r_color <= 16'h0000;
         r_out   <= 9'h000;
         r_empty <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x0    <= bus.x0;
                  r_x1    <= bus.x1;
                  r_y0    <= bus.y0;
                  r_y1    <= bus.y1;
                  r_color <= bus.color;
                  r_idx   <= 4'd0;
                  r_out   <= {1'b0, CMD_CASET};
                  r_empty <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= HEAD;
               end
            end
            HEAD: begin
               if (w_pop) begin
                  if (r_idx == HEAD_LAST) begin
                     r_out   <= {1'b1, r_color[15:8]};
                     r_state <= PIX;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                     r_out <= head_word(r_idx + 4'd1, 16'(r_x0), 16'(r_x1),
                                        16'(r_y0), 16'(r_y1));
                  end
               end
            end
            PIX: begin
               if (w_pop) begin
                  if (!w_phase) begin
                     r_out <= {1'b1, r_color[7:0]};
                  end else if (w_last) begin
                     r_out   <= 9'h000;
                     r_empty <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_out <= {1'b1, r_color[15:8]};
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_out   <= 9'h000;
               r_empty <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out   = r_out;
   assign bus.empty = r_empty;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule

// File: doc/display_fill.md
DISPLAY_FILL -- requirements
Module: display_fill

Interface
REQ-001 SHALL have parameter W, default 8, coordinate width (legal 1..16).
REQ-002 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one window fill; sampled only in IDLE.
REQ-005 SHALL have ports x0, x1, y0, y1  input  W each  inclusive window corners; latched on an accepted start.
REQ-006 SHALL have port color  input  16  RGB565 fill colour; latched on an accepted start.
REQ-007 SHALL have port get  input  1  consumer pops the current word (spi_display get).
REQ-008 SHALL have port out  output  9  bit 8 = D/C (0 command, 1 data), bits 7:0 = byte.
REQ-009 SHALL have port empty  output  1  high when no valid word is presented on out.
REQ-010 SHALL have port busy  output  1  high from accepted start until the last word is popped.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the clock edge that pops the last word.

Function
REQ-012 SHALL use states IDLE, HEAD, PIX.
REQ-013 In IDLE, start=1 with x0<=x1 and y0<=y1 SHALL latch inputs and enter HEAD at index 0 on the next edge; start is otherwise ignored with no output.
REQ-014 start while busy SHALL be ignored.
REQ-015 HEAD SHALL present 11 words in order: {0,2A}, {1,x0[15:8]}, {1,x0[7:0]}, {1,x1[15:8]}, {1,x1[7:0]}, {0,2B}, {1,y0 hi}, {1,y0 lo}, {1,y1 hi}, {1,y1 lo}, {0,2C}; coordinates zero-extended to 16 bits.
REQ-016 After word 10 is popped SHALL enter PIX with column=x0, row=y0, phase=high.
REQ-017 PIX SHALL present {1,color[15:8]} then {1,color[7:0]} per pixel, (x1-x0+1)*(y1-y0+1) pixels.
REQ-018 Pixel walk: after the low byte, column increments; at column==x1, column reloads x0 and row increments; low byte at column==x1 and row==y1 is the last word.
REQ-019 Column/row counters SHALL be W bits, compared by equality only; x1 or y1 at 2^W-1 SHALL NOT wrap or overrun.
REQ-020 empty SHALL be 0 in HEAD and PIX and 1 in IDLE; out SHALL be a registered or state-decoded value, stable while empty=0 and get=0.
REQ-021 A pop occurs on an edge with get=1 and empty=0; the next word (or IDLE) SHALL be visible the following cycle, sustaining one word per cycle.
REQ-022 get while empty=1 SHALL have no effect.
REQ-023 Popping the last word SHALL pulse done, clear busy, and return to IDLE on that edge; a start in the following cycle SHALL be accepted.
REQ-024 Single pixel window (x0=x1, y0=y1) SHALL yield exactly 11 header words plus 2 pixel words.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, empty=1, busy=0, done=0, out=0, counters and latched registers 0, regardless of clock.
REQ-026 Reset mid-fill SHALL abandon the sequence; no residual words after reset release.

Structure
REQ-027 Command opcodes CASET=2A, RASET=2B, RAMWR=2C and header length 11 SHALL be defined in a shared display-commands include for reuse by other display blocks.
REQ-028 The pixel walk (column/row counters, last detection) SHALL be a sub-module named display_window_walk; the header sequencer stays in display_fill.
REQ-029 Output pairs directly with spi_display (out[8] to dc input, out[7:0] to data, get/empty as handshake) with no glue.

Verification
REQ-030 Window x0=0,x1=1,y0=0,y1=0, color=F800, get held 1 -> 15 words: 02A,100,100,100,101,02B,100,100,100,100,02C,1F8,100,1F8,100; done once with the last.
REQ-031 x0=5,x1=4 start -> empty stays 1, busy stays 0, no words.
REQ-032 get toggled randomly over a 3x2 window, color=1234 -> identical word stream as with get=1; 12 pixel words alternating 112/134; no word duplicated or dropped.
REQ-033 W=8, x0=x1=y0=y1=255 -> header ends 1FF pair, exactly 2 pixel words, then IDLE.
REQ-034 reset asserted mid-PIX between clock edges -> empty=1, busy=0 before the next edge; new start after release yields a fresh header from 02A.
REQ-035 start asserted every cycle during a fill -> ignored; after done, next start accepted the following cycle.
